pid_sequencer: RTL and testbench
================================

// Module: pid_sequencer
// PURPOSE
// - Multi-cycle PID-loop controller: accepts one PV sample per valid/ready handshake and
//   computes error, the saturating integral, and the P and I products.
// - Uses ONE shared unsigned multiplier, time-multiplexed between the P and I terms.
// - Publishes a clamped stimulus with a one-cycle valid strobe.
// - Sits between the PV sampler (ADC/IO) and the actuator driver (PWM); replaces the parallel two-multiplier datapath.
// PARAMETERS
// - BITS  8  width of sp, pv, kp, ki and stimulus; multiplier is BITS x BITS -> 2*BITS
// PORTS
// - clk        in   1       clock, all state on rising edge
// - reset      in   1       synchronous, active-high
// - pv_valid   in   1       PV sample offered
// - pv_ready   out  1       block can accept sample (high only in IDLE)
// - pv         in   BITS    process value, unsigned
// - sp         in   BITS    setpoint, unsigned
// - kp         in   BITS    proportional gain, unsigned, Q0.BITS scaling via output slice
// - ki         in   BITS    integral gain, unsigned
// - int_clr    in   1       clear integral register (anti-windup / mode change)
// - busy       out  1       high in every state except IDLE
// - stimulus   out  BITS    controller output, held between updates
// - stim_valid out  1       one-cycle pulse when stimulus updates
// BEHAVIOUR
// - Reset (synchronous, active-high) sets:
//   - state = IDLE; stimulus = 0; stim_valid = 0; busy = 0.
//   - integral, error, pterm and iterm = 0.
//   - Reset in any state aborts the computation; pv_ready = 1 on the first cycle after reset deasserts.
// - FSM: IDLE -> ERR -> PMUL -> IMUL -> OUT -> IDLE (exactly one cycle per state after IDLE).
// - IDLE:
//   - pv_ready = 1.
//   - On pv_valid & pv_ready: register pv, sp, kp and ki; go to ERR.
//   - pv_valid while not ready is ignored; no sample is lost internally.
// - ERR:
//   - error = {0,sp} - {0,pv}, signed BITS+1.
//   - integral_next = integral + error, computed at BITS+2 signed, clamped to ±(2^BITS-1), stored as BITS+1 signed.
//   - The integral uses the new error.
// - PMUL: mul A = |error|[BITS-1:0], B = kp; pterm = signed(2*BITS+1) with sign of error.
// - IMUL: mul A = |integral|, B = ki; iterm likewise, with sign of integral.
// - OUT:
//   - sum = pterm + iterm, signed 2*BITS+2.
//   - stimulus = 0 if sum < 0; all-ones if sum >= 2^(2*BITS); else sum[2*BITS-1:BITS].
//   - stim_valid = 1 for this single edge.
// - Latency: acceptance at edge N -> stimulus/stim_valid registered at edge N+4; max throughput 1 sample / 5 cycles.
// - int_clr:
//   - Clears integral at any edge in any state.
//   - Wins over the ERR-state update.
//   - If asserted during PMUL, IMUL uses the cleared value 0.
// - stimulus changes only in OUT or on reset; sp/kp/ki changes mid-computation have no effect.
// STRUCTURE
// - Package pid_pkg:
//   - typedef enum state_t {IDLE, ERR, PMUL, IMUL, OUT};
//   - localparam for integral clamp magnitude 2^BITS-1, for BITS=8.
// - One sub-module: the existing combinational unsigned multiplier `mul` (BITS=2*BITS), single instance.
//   - Operands are muxed by state and zero-extended; the product takes [2*BITS-1:0].
// - Everything else (FSM, abs/sign, clamps) is inline.
// TESTING (BITS=8)
// - P only: sp=100, pv=60, kp=64, ki=0.
//   - Expect: pv_ready low 4 cycles; stim_valid exactly 4 edges after accept; stimulus=10.
// - Negative clamp: sp=10, pv=200, kp=255, ki=0 -> stimulus=0, stim_valid pulses.
// - Integral: sp=50, pv=40, kp=0, ki=128, three samples -> stimulus 5, 10, 15.
//   - Then int_clr plus a fourth sample -> stimulus 5.
// - Saturation: sp=255, pv=0, kp=255, ki=255, two samples.
//   - Expect: integral clamps at 255; sum=130050 >= 65536 -> stimulus=255 both times.
// - Handshake: hold pv_valid high continuously -> accepts exactly every 5 cycles.
//   - Also: pv_valid pulse while busy is ignored -> no extra stim_valid.
// - Reset mid-op: assert reset in PMUL.
//   - Expect: stimulus=0, stim_valid never pulses; pv_ready=1 on the next cycle after reset deasserts.
//   - Next sample computes from integral=0.

Source files
------------

// File: rtl/pid_sequencer_pkg.sv
// pid_pkg: shared FSM states and integral clamp helpers for the PID sequencer
package pid_pkg;

    typedef enum logic [2:0] {IDLE, ERR, PMUL, IMUL, OUT} state_t;

    function automatic int int_lim(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int INT_CLAMP = int_lim(8);

endpackage

// File: rtl/pid_sequencer_mul.sv
// mul: combinational unsigned multiplier, full-width product
module mul #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0]   i_a,
    input  logic [BITS-1:0]   i_b,
    output logic [2*BITS-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/pid_sequencer.sv
// pid_sequencer: multi-cycle PID controller sharing one multiplier between the P and I terms
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pv_valid,
    output logic            pv_ready,
    input  logic [BITS-1:0] pv,
    input  logic [BITS-1:0] sp,
    input  logic [BITS-1:0] kp,
    input  logic [BITS-1:0] ki,
    input  logic            int_clr,
    output logic            busy,
    output logic [BITS-1:0] stimulus,
    output logic            stim_valid
);

    localparam logic signed [BITS+1:0] LIM = (BITS+2)'(int_lim(BITS));

    state_t                   r_state, w_next;
    logic [BITS-1:0]          r_pv, r_sp, r_kp, r_ki, r_stim;
    logic                     r_stim_valid;
    logic signed [BITS:0]     r_err, r_int, w_err;
    logic signed [BITS+1:0]   w_int_sum, w_int_sat;
    logic signed [2*BITS:0]   r_pterm, r_iterm, w_term;
    logic signed [2*BITS+1:0] w_sum;
    logic [2*BITS:0]          w_mag;
    logic [BITS-1:0]          w_mul_a, w_mul_b, w_stim;
    logic [4*BITS-1:0]        w_prod;
    logic                     w_neg, w_pmul, w_unused;

    assign pv_ready   = (r_state == IDLE);
    assign busy       = ~pv_ready;
    assign stimulus   = r_stim;
    assign stim_valid = r_stim_valid;

    assign w_err     = {1'b0, r_sp} - {1'b0, r_pv};
    assign w_int_sum = {r_int[BITS], r_int} + {w_err[BITS], w_err};
    assign w_int_sat = (w_int_sum > LIM) ? LIM : (w_int_sum < -LIM) ? -LIM : w_int_sum;

    // Operands are sign-magnitude: the multiplier only ever sees magnitudes
    assign w_pmul  = (r_state == PMUL);
    assign w_neg   = w_pmul ? r_err[BITS] : r_int[BITS];
    assign w_mul_a = w_pmul ? (r_err[BITS] ? BITS'(-r_err) : r_err[BITS-1:0])
                            : (r_int[BITS] ? BITS'(-r_int) : r_int[BITS-1:0]);
    assign w_mul_b = w_pmul ? r_kp : r_ki;

    mul #(.BITS(2*BITS)) u_mul (
        .i_a({{BITS{1'b0}}, w_mul_a}),
        .i_b({{BITS{1'b0}}, w_mul_b}),
        .o_p(w_prod)
    );

    assign w_mag    = {1'b0, w_prod[2*BITS-1:0]};
    assign w_term   = w_neg ? -w_mag : w_mag;
    assign w_sum    = {r_pterm[2*BITS], r_pterm} + {r_iterm[2*BITS], r_iterm};
    assign w_stim   = w_sum[2*BITS+1] ? '0 : w_sum[2*BITS] ? '1 : w_sum[2*BITS-1:BITS];
    assign w_unused = ^{w_prod[4*BITS-1:2*BITS], w_sum[BITS-1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state: one cycle per stage once a sample is accepted
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = pv_valid ? ERR : IDLE;
            ERR:     w_next = PMUL;
            PMUL:    w_next = IMUL;
            IMUL:    w_next = OUT;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, error/integral, the two products and the clamped output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pv         <= '0;
            r_sp         <= '0;
            r_kp         <= '0;
            r_ki         <= '0;
            r_err        <= '0;
            r_int        <= '0;
            r_pterm      <= '0;
            r_iterm      <= '0;
            r_stim       <= '0;
            r_stim_valid <= 1'b0;
        end else begin
            r_stim_valid <= 1'b0;
            if (r_state == IDLE && pv_valid) begin
                r_pv <= pv;
                r_sp <= sp;
                r_kp <= kp;
                r_ki <= ki;
            end
            if (r_state == ERR) r_err <= w_err;
            if (int_clr)               r_int <= '0;
            else if (r_state == ERR)   r_int <= w_int_sat[BITS:0];
            if (r_state == PMUL) r_pterm <= w_term;
            if (r_state == IMUL) r_iterm <= w_term;
            if (r_state == OUT) begin
                r_stim       <= w_stim;
                r_stim_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// tb_pid_sequencer: directed checks of the PID sequencer with hand-computed results
module tb_pid_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pv_valid = 1'b0;
    logic       int_clr = 1'b0;
    logic [7:0] pv = '0, sp = '0, kp = '0, ki = '0;
    logic       pv_ready, busy, stim_valid;
    logic [7:0] stimulus;
    int         total = 0;
    int         bad = 0;

    pid_sequencer #(.BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .pv_valid(pv_valid),
        .pv_ready(pv_ready),
        .pv(pv),
        .sp(sp),
        .kp(kp),
        .ki(ki),
        .int_clr(int_clr),
        .busy(busy),
        .stimulus(stimulus),
        .stim_valid(stim_valid)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers one sample from IDLE, scrambles inputs while busy, optional int_clr at stage clr_at
    task automatic run_sample(input string tag, input logic [7:0] s, p, k, i,
                              input int clr_at, input logic [7:0] exp);
        logic ok;
        ok = 1'b1;
        sp = s; pv = p; kp = k; ki = i;
        pv_valid = 1'b1;
        chk({tag, "_ready"}, pv_ready, 1);
        step;
        pv_valid = 1'b0;
        sp = ~s; pv = ~p; kp = ~k; ki = ~i;
        for (int c = 1; c <= 3; c++) begin
            ok &= (pv_ready === 1'b0) && (busy === 1'b1) && (stim_valid === 1'b0);
            int_clr = (c == clr_at);
            step;
            int_clr = 1'b0;
        end
        ok &= (pv_ready === 1'b0) && (stim_valid === 1'b0);
        step;
        chk({tag, "_busy"}, ok, 1);
        chk({tag, "_valid"}, stim_valid, 1);
        chk({tag, "_stim"}, stimulus, exp);
        chk({tag, "_idle"}, pv_ready, 1);
        step;
        chk({tag, "_pulse"}, stim_valid, 0);
    endtask

    initial begin
        logic ok;
        int   nv;
        step;
        step;
        reset = 1'b0;
        chk("rst_stim", stimulus, 0);
        chk("rst_valid", stim_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pv_ready, 1);

        run_sample("p_only", 8'd100, 8'd60, 8'd64, 8'd0, 0, 8'd10);
        run_sample("neg_clamp", 8'd10, 8'd200, 8'd255, 8'd0, 0, 8'd0);

        int_clr = 1'b1; step; int_clr = 1'b0;
        run_sample("int1", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd5);
        run_sample("int2", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd10);
        run_sample("int3", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd15);
        int_clr = 1'b1; step; int_clr = 1'b0;
        run_sample("int4", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd5);
        run_sample("clr_pmul", 8'd50, 8'd40, 8'd0, 8'd128, 2, 8'd0);
        run_sample("after_clr", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd5);

        run_sample("sat1", 8'd255, 8'd0, 8'd255, 8'd255, 0, 8'd255);
        run_sample("sat2", 8'd255, 8'd0, 8'd255, 8'd255, 0, 8'd255);
        run_sample("int_held", 8'd0, 8'd0, 8'd0, 8'd255, 0, 8'd254);

        sp = 8'd100; pv = 8'd60; kp = 8'd64; ki = 8'd0;
        pv_valid = 1'b1;
        ok = 1'b1;
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            ok &= (pv_ready === (c % 5 == 0));
            nv += int'(stim_valid);
            step;
        end
        pv_valid = 1'b0;
        chk("hs_cadence", ok, 1);
        chk("hs_pulses", nv, 2);
        chk("hs_last_valid", stim_valid, 1);
        chk("hs_last_stim", stimulus, 10);
        step;

        pv_valid = 1'b1;
        step;
        pv_valid = 1'b0;
        step;
        pv_valid = 1'b1;
        step;
        pv_valid = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            nv += int'(stim_valid);
            step;
        end
        chk("busy_ignore_pulses", nv, 1);
        chk("busy_ignore_ready", pv_ready, 1);

        sp = 8'd255; pv = 8'd0; kp = 8'd255; ki = 8'd255;
        pv_valid = 1'b1;
        step;
        pv_valid = 1'b0;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("midrst_stim", stimulus, 0);
        chk("midrst_valid", stim_valid, 0);
        chk("midrst_ready", pv_ready, 1);
        chk("midrst_busy", busy, 0);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            nv += int'(stim_valid);
            step;
        end
        chk("midrst_no_pulse", nv, 0);
        run_sample("post_reset", 8'd50, 8'd40, 8'd0, 8'd128, 0, 8'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
